// File: rtl/fcl_multi_controller_pkg.sv
// Shared types for the field-config-loader controller.
// State encoding, request bundle and legacy two-config request mapping.
package fcl_multi_controller_pkg;

  localparam int FCL_NUM_CFGS  = 4;
  localparam int FCL_CFG_IDX_W = $clog2(FCL_NUM_CFGS);

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    START_LOADING = 2'd1,
    WAIT_LOAD_END = 2'd2
  } fcl_ctrl_state_t;

  typedef struct packed {
    logic                     valid;
    logic [FCL_CFG_IDX_W-1:0] idx;
  } fcl_req_t;

  typedef enum logic [1:0] {
    NO_CFG = 2'd0,
    CFG_1  = 2'd1,
    CFG_2  = 2'd2
  } load_cfg_req_t;

  // Old two-config requests land on indices 0 and 1.
  function automatic fcl_req_t legacy_to_req(
    input load_cfg_req_t r
  );
    fcl_req_t q;
    q = '0;
    unique case (r)
      CFG_1: begin
        q.valid = 1'b1;
        q.idx   = FCL_CFG_IDX_W'(0);
      end
      CFG_2: begin
        q.valid = 1'b1;
        q.idx   = FCL_CFG_IDX_W'(1);
      end
      default: q = '0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/fcl_multi_controller_req_arbiter.sv
// Lowest-index priority encoder over the load-config command lines.
// Emits a {valid, idx} request bundle of caller-chosen type.
module fcl_req_arbiter
  import fcl_multi_controller_pkg::*;
#(
  parameter int  NUM_CFGS = FCL_NUM_CFGS,
  parameter type req_t    = fcl_req_t
) (
  input  logic [NUM_CFGS-1:0] cmd,
  output req_t                req
);

  localparam int IDX_W = $bits(req_t) - 1;

  always_comb begin
    req = '0;
    for (int i = NUM_CFGS - 1; i >= 0; i--) begin
      if (cmd[i]) begin
        req.valid = 1'b1;
        req.idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/fcl_multi_controller.sv
// Arbitrates NUM_CFGS sticky load requests into one-cycle loader starts,
// with one queued follow-up request, abort and a load watchdog.
module fcl_multi_controller
  import fcl_multi_controller_pkg::*;
#(
  parameter int NUM_CFGS       = FCL_NUM_CFGS,
  parameter int CFG_IDX_W      = $clog2(NUM_CFGS),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CFGS-1:0]  i_cmd_load_cfg,
  input  logic                 i_FCL_allowed,
  input  logic                 i_is_loading,
  input  logic                 i_abort,
  output logic                 o_go,
  output logic [CFG_IDX_W-1:0] o_cfg_idx,
  output logic                 o_cfg_valid,
  output logic                 o_pending,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_timeout
);

  typedef struct packed {
    logic                 valid;
    logic [CFG_IDX_W-1:0] idx;
  } req_t;

  localparam int WD_W =
    (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX = {WD_W{1'b1}};

  fcl_ctrl_state_t state, state_d;
  req_t            cur, cur_d;
  req_t            pend, pend_d;
  req_t            sel;
  logic [WD_W-1:0] wd, wd_d;
  logic            wd_hit;
  logic            done;
  logic            timeout;

  fcl_req_arbiter #(
    .NUM_CFGS(NUM_CFGS),
    .req_t   (req_t)
  ) u_arb (
    .cmd(i_cmd_load_cfg),
    .req(sel)
  );

  assign wd_hit = WD_EN && (wd == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur   <= '0;
      pend  <= '0;
      wd    <= '0;
    end else begin
      state <= state_d;
      cur   <= cur_d;
      pend  <= pend_d;
      wd    <= wd_d;
    end
  end

  always_comb begin
    state_d = state;
    cur_d   = cur;
    pend_d  = pend;
    wd_d    = wd;
    done    = 1'b0;
    timeout = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_abort) begin
          cur_d.valid  = 1'b0;
          pend_d.valid = 1'b0;
        end else if (cur.valid && i_FCL_allowed) begin
          state_d = START_LOADING;
          if (sel.valid) pend_d = sel;
        end else if (sel.valid) begin
          cur_d = sel;
        end
      end
      START_LOADING: begin
        wd_d = '0;
        if (i_abort) begin
          state_d     = IDLE;
          cur_d.valid = 1'b0;
        end else begin
          state_d = WAIT_LOAD_END;
          if (sel.valid) pend_d = sel;
        end
      end
      WAIT_LOAD_END: begin
        if (wd != WD_MAX) wd_d = wd + 1'b1;
        if (i_abort) begin
          state_d     = IDLE;
          cur_d.valid = 1'b0;
        end else if (!i_is_loading) begin
          done    = 1'b1;
          state_d = IDLE;
          // Queued request is promoted; a same-cycle command refills the queue.
          if (pend.valid) begin
            cur_d  = pend;
            pend_d = sel.valid ? sel : '0;
          end else if (sel.valid) begin
            cur_d = sel;
          end else begin
            cur_d.valid = 1'b0;
          end
        end else if (wd_hit) begin
          timeout     = 1'b1;
          state_d     = IDLE;
          cur_d.valid = 1'b0;
          if (sel.valid) pend_d = sel;
        end else if (sel.valid) begin
          pend_d = sel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_go        = (state == START_LOADING);
  assign o_busy      = (state != IDLE);
  assign o_cfg_idx   = cur.idx;
  assign o_cfg_valid = cur.valid;
  assign o_pending   = pend.valid;
  assign o_done      = done;
  assign o_timeout   = timeout;

endmodule

// File: tb/tb_fcl_multi_controller.sv
// Directed bench for fcl_multi_controller with a go-index scoreboard
// and a simple loader model that stays busy for a set number of cycles.
module tb_fcl_multi_controller;

  localparam int NC = 4;
  localparam int IW = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NC-1:0] cmd;
  logic          allowed;
  logic          is_loading;
  logic          abort;
  logic          o_go;
  logic [IW-1:0] o_cfg_idx;
  logic          o_cfg_valid;
  logic          o_pending;
  logic          o_busy;
  logic          o_done;
  logic          o_timeout;

  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;
  int to_cnt   = 0;
  int load_len = 5;
  int load_cnt = 0;
  logic stuck  = 1'b0;
  int exp_q[$];

  fcl_multi_controller #(
    .NUM_CFGS      (NC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cmd_load_cfg(cmd),
    .i_FCL_allowed (allowed),
    .i_is_loading  (is_loading),
    .i_abort       (abort),
    .o_go          (o_go),
    .o_cfg_idx     (o_cfg_idx),
    .o_cfg_valid   (o_cfg_valid),
    .o_pending     (o_pending),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_timeout     (o_timeout)
  );

  always #5 clk = ~clk;

  // Loader: goes busy the cycle after go, for load_len cycles.
  assign is_loading = stuck || (load_cnt != 0);

  always @(posedge clk) begin
    if (o_go) load_cnt <= load_len;
    else if (load_cnt != 0) load_cnt <= load_cnt - 1;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (o_done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 50), 32'd1);
  endtask

  // Scoreboard: every go must match the next expected config index.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_go) begin
        if (exp_q.size() == 0) check("unexpected_go", 32'd1, 32'd0);
        else check("go_idx", 32'(o_cfg_idx), 32'(exp_q.pop_front()));
      end
      if (o_done) done_cnt++;
      if (o_timeout) to_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_n = 1'b0; cmd = '0; allowed = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", 32'({o_go, o_cfg_idx, o_cfg_valid, o_pending,
                             o_busy, o_done, o_timeout}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, loader busy 5 cycles
    allowed = 1'b1; cmd = 4'b0100; exp_q.push_back(2);
    @(negedge clk); cmd = '0;
    check("t1_valid", 32'(o_cfg_valid), 32'd1);
    check("t1_idx", 32'(o_cfg_idx), 32'd2);
    check("t1_nogo_early", 32'(o_go), 32'd0);
    @(negedge clk);
    check("t1_go", 32'(o_go), 32'd1);
    wait_done("t1_done_seen");
    repeat (2) @(negedge clk);
    check("t1_done_once", 32'(done_cnt), 32'd1);
    check("t1_idle", 32'(o_busy), 32'd0);
    check("t1_cleared", 32'(o_cfg_valid), 32'd0);

    // Sticky request held while loading is not allowed
    allowed = 1'b0; cmd = 4'b1000;
    @(negedge clk); cmd = '0;
    repeat (19) @(negedge clk);
    check("t2_sticky_valid", 32'(o_cfg_valid), 32'd1);
    check("t2_sticky_idx", 32'(o_cfg_idx), 32'd3);
    check("t2_held_idle", 32'(o_busy), 32'd0);
    exp_q.push_back(3); allowed = 1'b1;
    @(negedge clk);
    check("t2_go_after_allow", 32'(o_go), 32'd1);
    wait_done("t2_done_seen");
    repeat (2) @(negedge clk);
    check("t2_done_cnt", 32'(done_cnt), 32'd2);

    // Priority plus a queued request that reloads automatically
    cmd = 4'b1010; exp_q.push_back(1);
    @(negedge clk); cmd = '0;
    check("t3_prio_idx", 32'(o_cfg_idx), 32'd1);
    @(negedge clk); cmd = 4'b1000;
    check("t3_go", 32'(o_go), 32'd1);
    @(negedge clk); cmd = 4'b0100;
    @(negedge clk); cmd = '0;
    check("t3_pending", 32'(o_pending), 32'd1);
    check("t3_idx_stable", 32'(o_cfg_idx), 32'd1);
    exp_q.push_back(2);
    wait_done("t3_done1_seen");
    @(negedge clk);
    check("t3_promoted_idx", 32'(o_cfg_idx), 32'd2);
    check("t3_promoted_valid", 32'(o_cfg_valid), 32'd1);
    check("t3_pend_cleared", 32'(o_pending), 32'd0);
    @(negedge clk);
    check("t3_second_go", 32'(o_go), 32'd1);
    wait_done("t3_done2_seen");
    repeat (2) @(negedge clk);
    check("t3_done_cnt", 32'(done_cnt), 32'd4);
    check("t3_final_valid", 32'(o_cfg_valid), 32'd0);

    // Watchdog with loader stuck busy, pending request survives
    cmd = 4'b0001; exp_q.push_back(0);
    @(negedge clk); cmd = '0;
    @(negedge clk); stuck = 1'b1;
    check("t4_go", 32'(o_go), 32'd1);
    @(negedge clk); cmd = 4'b0100;
    @(negedge clk); cmd = '0;
    repeat (5) @(negedge clk);
    check("t4_no_early_to", 32'(to_cnt), 32'd0);
    @(negedge clk);
    check("t4_timeout", 32'(o_timeout), 32'd1);
    check("t4_no_done", 32'(o_done), 32'd0);
    @(negedge clk); stuck = 1'b0;
    check("t4_idle", 32'(o_busy), 32'd0);
    check("t4_cur_cleared", 32'(o_cfg_valid), 32'd0);
    check("t4_pend_kept", 32'(o_pending), 32'd1);
    check("t4_to_once", 32'(to_cnt), 32'd1);
    check("t4_done_cnt", 32'(done_cnt), 32'd4);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("t4_abort_idle_pend", 32'(o_pending), 32'd0);

    // Abort in the third WAIT cycle
    load_len = 10; cmd = 4'b0010; exp_q.push_back(1);
    @(negedge clk); cmd = '0;
    @(negedge clk);
    check("t5_go", 32'(o_go), 32'd1);
    repeat (3) @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("t5_abort_idle", 32'(o_busy), 32'd0);
    check("t5_abort_cleared", 32'(o_cfg_valid), 32'd0);
    repeat (12) @(negedge clk);
    check("t5_no_done", 32'(done_cnt), 32'd4);

    // Asynchronous reset in the middle of a load
    cmd = 4'b1000; exp_q.push_back(3);
    @(negedge clk); cmd = '0;
    @(negedge clk);
    check("t6_go", 32'(o_go), 32'd1);
    repeat (2) @(negedge clk);
    check("t6_busy_before", 32'(o_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_reset", 32'({o_go, o_cfg_idx, o_cfg_valid, o_pending,
                                 o_busy, o_done, o_timeout}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("t6_idle_after", 32'(o_busy), 32'd0);
    check("t6_no_done", 32'(done_cnt), 32'd4);
    check("go_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
